// File: rtl/forward_ctrl.sv
// forward_ctrl: operand-forwarding select and load-use stall control for a
// 5-stage pipeline. Shadows the EXE/MEM/WB slots' register usage so the
// datapath only needs the three select buses and the stall line.
module forward_ctrl #(
  parameter int REG_ADDR_LEN    = 5,
  parameter int FORWARD_SEL_LEN = 2,
  parameter int CNT_LEN         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       flush,
  input  logic                       id_valid,
  input  logic [REG_ADDR_LEN-1:0]    id_src1,
  input  logic [REG_ADDR_LEN-1:0]    id_src2,
  input  logic                       id_use1,
  input  logic                       id_use2,
  input  logic                       id_is_store,
  input  logic [REG_ADDR_LEN-1:0]    id_st_src,
  input  logic [REG_ADDR_LEN-1:0]    id_dest,
  input  logic                       id_wb_en,
  input  logic                       id_mem_read,
  output logic [FORWARD_SEL_LEN-1:0] val1_sel,
  output logic [FORWARD_SEL_LEN-1:0] val2_sel,
  output logic [FORWARD_SEL_LEN-1:0] ST_val_sel,
  output logic                       stall,
  output logic [CNT_LEN-1:0]         stall_cnt
);

  localparam logic [FORWARD_SEL_LEN-1:0] SEL_REG = FORWARD_SEL_LEN'(0);
  localparam logic [FORWARD_SEL_LEN-1:0] SEL_MEM = FORWARD_SEL_LEN'(1);
  localparam logic [FORWARD_SEL_LEN-1:0] SEL_WB  = FORWARD_SEL_LEN'(2);

  typedef struct packed {
    logic                    valid;
    logic [REG_ADDR_LEN-1:0] src1;
    logic [REG_ADDR_LEN-1:0] src2;
    logic                    use1;
    logic                    use2;
    logic                    is_store;
    logic [REG_ADDR_LEN-1:0] st_src;
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    wb_en;
    logic                    mem_read;
  } slot_t;

  slot_t exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
  slot_t id_slot, bubble;
  logic [CNT_LEN-1:0] stall_cnt_q, stall_cnt_d;
  logic               src_hit, load_use;

  // A slot may feed a result forward only if it really writes a non-zero reg.
  function automatic logic producer(input slot_t s);
    return s.valid && s.wb_en && (s.dest != '0);
  endfunction

  // Youngest producer wins; a load still in MEM has no data yet, so it is
  // skipped (the stall guarantees it is already in WB when consumed).
  function automatic logic [FORWARD_SEL_LEN-1:0] fwd_sel(
    input slot_t                   exe,
    input slot_t                   mem,
    input slot_t                   wb,
    input logic [REG_ADDR_LEN-1:0] src,
    input logic                    used
  );
    logic [FORWARD_SEL_LEN-1:0] sel;
    sel = SEL_REG;
    if (exe.valid && used) begin
      if (producer(mem) && !mem.mem_read && mem.dest == src) sel = SEL_MEM;
      else if (producer(wb) && wb.dest == src)               sel = SEL_WB;
    end
    return sel;
  endfunction

  // Pack the ID-stage decode into a slot image; build the bubble image.
  always_comb begin
    id_slot          = '0;
    id_slot.valid    = id_valid;
    id_slot.src1     = id_src1;
    id_slot.src2     = id_src2;
    id_slot.use1     = id_use1;
    id_slot.use2     = id_use2;
    id_slot.is_store = id_is_store;
    id_slot.st_src   = id_st_src;
    id_slot.dest     = id_dest;
    id_slot.wb_en    = id_wb_en;
    id_slot.mem_read = id_mem_read;
    bubble           = '0;
  end

  // Load-use detection against the load sitting in EXE; flush wins over stall.
  always_comb begin
    src_hit  = (id_use1     && exe_q.dest == id_src1) ||
               (id_use2     && exe_q.dest == id_src2) ||
               (id_is_store && exe_q.dest == id_st_src);
    load_use = id_valid && exe_q.valid && exe_q.mem_read && exe_q.wb_en &&
               (exe_q.dest != '0) && src_hit;
    stall    = load_use && !flush;
  end

  // Slot shift and stall counter next-state; freeze holds everything.
  always_comb begin
    exe_d       = exe_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      exe_d = (stall || flush) ? bubble : id_slot;
      mem_d = exe_q;
      wb_d  = mem_q;
      if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q       <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      exe_q       <= exe_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Forwarding selects for the instruction in EXE, straight from slot state.
  always_comb begin
    val1_sel   = fwd_sel(exe_q, mem_q, wb_q, exe_q.src1,   exe_q.use1);
    val2_sel   = fwd_sel(exe_q, mem_q, wb_q, exe_q.src2,   exe_q.use2);
    ST_val_sel = fwd_sel(exe_q, mem_q, wb_q, exe_q.st_src, exe_q.is_store);
    stall_cnt  = stall_cnt_q;
  end

endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl: directed instruction sequences with hand-computed selects,
// stall and counter values. A 4-bit-counter twin checks saturation.
module tb_forward_ctrl;
  logic       clk = 1'b0;
  logic       rst, freeze, flush;
  logic       id_valid, id_use1, id_use2, id_is_store, id_wb_en, id_mem_read;
  logic [4:0] id_src1, id_src2, id_st_src, id_dest;
  logic [1:0] val1_sel, val2_sel, ST_val_sel;
  logic       stall;
  logic [15:0] stall_cnt;
  logic [1:0] s_v1, s_v2, s_st;
  logic       s_stall;
  logic [3:0] s_cnt;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  forward_ctrl dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_is_store(id_is_store),
    .id_st_src(id_st_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .val1_sel(val1_sel), .val2_sel(val2_sel),
    .ST_val_sel(ST_val_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  forward_ctrl #(.CNT_LEN(4)) sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_is_store(id_is_store),
    .id_st_src(id_st_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .val1_sel(s_v1), .val2_sel(s_v2),
    .ST_val_sel(s_st), .stall(s_stall), .stall_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1, input logic u1,
                        input logic [4:0] s2, input logic u2, input logic st,
                        input logic [4:0] sts, input logic [4:0] d,
                        input logic wb, input logic mr);
    id_valid = v; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
    id_is_store = st; id_st_src = sts; id_dest = d; id_wb_en = wb; id_mem_read = mr;
  endtask

  task automatic nop();                               set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input logic [4:0] d, s1, s2);    set_id(1, s1, 1, s2, 1, 0, 0, d, 1, 0); endtask
  task automatic lw(input logic [4:0] d, base);       set_id(1, base, 1, 0, 0, 0, 0, d, 1, 1); endtask
  task automatic sw(input logic [4:0] base, data);    set_id(1, base, 1, 0, 0, 1, data, 0, 0, 0); endtask
  task automatic tick();                              @(posedge clk); #1; endtask
  task automatic drain();                             nop(); repeat (3) tick(); endtask

  task automatic sels(input string tag, input logic [1:0] e1, e2, es);
    chk({tag, ".v1"}, val1_sel, e1);
    chk({tag, ".v2"}, val2_sel, e2);
    chk({tag, ".st"}, ST_val_sel, es);
  endtask

  initial begin
    rst = 1; freeze = 0; flush = 0; nop();
    #2;
    sels("reset", 0, 0, 0);
    chk("reset.stall", stall, 0);
    chk("reset.cnt", stall_cnt, 0);
    @(negedge clk); rst = 0;

    // EX->EX forwarding from MEM
    alu(3, 1, 2); tick();
    alu(4, 3, 1); tick();
    nop(); #1;
    sels("sub_after_add", 1, 0, 0);
    chk("sub_after_add.stall", stall, 0);

    // WB forwarding through a gap
    drain();
    alu(3, 1, 2); tick();
    nop(); tick();
    alu(5, 1, 3); tick();
    nop(); #1;
    sels("and_wb", 0, 2, 0);

    // MEM beats WB
    alu(3, 1, 2); tick();
    alu(3, 1, 2); tick();
    alu(6, 3, 3); tick();
    nop(); #1;
    sels("or_mem_prio", 1, 1, 0);

    // load-use: one stall then WB forwarding
    drain();
    lw(7, 1); tick();
    alu(8, 7, 2); #1;
    chk("lu.stall", stall, 1);
    chk("lu.cnt0", stall_cnt, 0);
    tick();
    chk("lu.stall_gone", stall, 0);
    chk("lu.cnt1", stall_cnt, 1);
    sels("lu.bubble", 0, 0, 0);
    tick();
    nop(); #1;
    sels("lu.add", 2, 0, 0);

    // load then store of the loaded value
    drain();
    lw(7, 1); tick();
    sw(2, 7); #1;
    chk("lsw.stall", stall, 1);
    tick();
    chk("lsw.stall_gone", stall, 0);
    chk("lsw.cnt2", stall_cnt, 2);
    tick();
    nop(); #1;
    sels("lsw.sw", 0, 0, 2);

    // r0 is never forwarded nor hazarded
    drain();
    alu(0, 1, 2); tick();
    lw(0, 1); tick();
    alu(9, 0, 0); #1;
    chk("r0.stall", stall, 0);
    tick();
    nop(); #1;
    sels("r0.reader", 0, 0, 0);

    // flush in the hazard cycle: no stall, flushed instr becomes a bubble
    drain();
    lw(7, 1); tick();
    alu(8, 7, 2); flush = 1; #1;
    chk("flush.stall", stall, 0);
    tick();
    flush = 0; alu(10, 8, 8); tick();
    nop(); #1;
    sels("flush.bubble", 0, 0, 0);
    chk("flush.cnt", stall_cnt, 2);

    // freeze during a hazard holds everything
    drain();
    alu(1, 2, 3); tick();
    lw(7, 1); tick();
    alu(8, 7, 2); freeze = 1; #1;
    chk("frz.stall0", stall, 1);
    sels("frz.sel0", 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz.stall", stall, 1);
      sels("frz.sel", 1, 0, 0);
      chk("frz.cnt", stall_cnt, 2);
    end
    freeze = 0; tick();
    chk("frz.release_cnt", stall_cnt, 3);
    chk("frz.release_stall", stall, 0);

    // async reset mid-stall
    drain();
    alu(1, 2, 3); tick();
    lw(7, 1); tick();
    alu(8, 7, 2); #1;
    chk("rst.pre_stall", stall, 1);
    sels("rst.pre_sel", 1, 0, 0);
    #1 rst = 1; #1;
    chk("rst.stall", stall, 0);
    chk("rst.cnt", stall_cnt, 0);
    sels("rst.sel", 0, 0, 0);
    @(negedge clk); rst = 0; #1;
    chk("rst.after_stall", stall, 0);
    tick();
    sels("rst.after_sel", 0, 0, 0);

    // saturation, on the narrow-counter twin
    rst = 1; #1; rst = 0; nop(); tick();
    for (int i = 0; i < 14; i++) begin
      lw(7, 1); tick();
      alu(8, 7, 2); tick();
    end
    chk("sat.small14", s_cnt, 14);
    chk("sat.big14", stall_cnt, 14);
    lw(7, 1); tick(); alu(8, 7, 2); tick();
    chk("sat.small15", s_cnt, 4'hF);
    lw(7, 1); tick(); alu(8, 7, 2); tick();
    chk("sat.small_hold", s_cnt, 4'hF);
    chk("sat.big16", stall_cnt, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 The module SHALL have parameter REG_ADDR_LEN, default 5, register-address width.
REQ-002 The module SHALL have parameter FORWARD_SEL_LEN, default 2, select width; encoding 0=register value, 1=MEM ALU result, 2=WB result.
REQ-003 The module SHALL have parameter CNT_LEN, default 16, stall-counter width.
REQ-004 Port clk, input, 1: single clock, all state on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port freeze, input, 1: global pipeline hold (memory wait); all slots hold when 1.
REQ-007 Port flush, input, 1: branch taken; squash the ID instruction.
REQ-008 Port id_valid, input, 1: ID stage holds a real instruction.
REQ-009 Port id_src1 / id_src2, input, REG_ADDR_LEN each: ALU operand source registers.
REQ-010 Port id_use1 / id_use2, input, 1 each: operand actually reads its register.
REQ-011 Port id_is_store, input, 1: instruction is a store; id_st_src is its data register.
REQ-012 Port id_st_src, input, REG_ADDR_LEN: store-data source register.
REQ-013 Port id_dest, input, REG_ADDR_LEN; id_wb_en, input, 1; id_mem_read, input, 1: writeback target, writeback enable, load flag.
REQ-014 Port val1_sel / val2_sel / ST_val_sel, output, FORWARD_SEL_LEN each: selects for the instruction currently in EXE.
REQ-015 Port stall, output, 1: hold PC and ID, insert bubble into EXE.
REQ-016 Port stall_cnt, output, CNT_LEN: saturating count of stall cycles.

Function
REQ-017 The module SHALL keep three shadow slots EXE, MEM, WB, each holding valid, src1, src2, use1, use2, is_store, st_src, dest, wb_en, mem_read.
REQ-018 On a clock edge with freeze=0, slots SHALL shift ID->EXE->MEM->WB; WB contents are discarded.
REQ-019 With freeze=1, all slots and stall_cnt SHALL hold; stall SHALL still be computed combinationally.
REQ-020 Load-use hazard: stall=1 iff id_valid, EXE.valid, EXE.mem_read, EXE.wb_en, EXE.dest!=0, and EXE.dest equals id_src1 (id_use1), id_src2 (id_use2), or id_st_src (id_is_store).
REQ-021 When stall=1 and freeze=0, the EXE slot SHALL load a bubble (valid=0) while MEM and WB still shift.
REQ-022 When flush=1 and freeze=0, the EXE slot SHALL load a bubble; flush overrides stall and stall SHALL be forced to 0.
REQ-023 A slot qualifies as a forwarding source only if valid=1, wb_en=1 and dest!=0; register 0 is never forwarded.
REQ-024 val1_sel SHALL be 1 if EXE.use1 and a qualifying MEM slot has dest==EXE.src1 and mem_read=0; else 2 if a qualifying WB slot matches; else 0.
REQ-025 val2_sel SHALL follow REQ-024 using src2/use2; ST_val_sel SHALL follow REQ-024 using st_src/is_store.
REQ-026 MEM match SHALL take priority over WB match (youngest producer wins).
REQ-027 A MEM-slot load matching an EXE source SHALL NOT select 1; REQ-020 guarantees the load has reached WB, so select 2 applies.
REQ-028 All select outputs SHALL be 0 when EXE.valid=0.
REQ-029 Select outputs SHALL be combinational from slot state (zero added latency).
REQ-030 stall_cnt SHALL increment by one on each edge with stall=1 and freeze=0, saturating at all-ones.

Reset
REQ-031 While rst=1 all slots SHALL be invalid; val1_sel, val2_sel, ST_val_sel=0, stall=0, stall_cnt=0, regardless of clk.
REQ-032 Reset asserted mid-stall SHALL clear stall immediately; after release the first instruction SHALL be evaluated without memory of prior state.

Verification
REQ-033 ADD r3 then SUB r4,r3,r1 back-to-back -> when SUB in EXE, val1_sel=1, val2_sel=0.
REQ-034 ADD r3; NOP; AND r5,r1,r3 -> when AND in EXE, val2_sel=2; ADD r3; ADD r3; OR r6,r3,r3 -> val1_sel=val2_sel=1 (MEM priority).
REQ-035 LW r7; ADD r8,r7,r2 -> stall=1 exactly one cycle, stall_cnt 0->1, EXE bubble, then ADD in EXE with val1_sel=2.
REQ-036 LW r7 then SW r7 (data) -> one-cycle stall, then ST_val_sel=2; writes to r0 followed by a reader of r0 -> all selects 0, no stall.
REQ-037 Load-use with flush=1 same cycle -> stall=0, EXE bubble; freeze=1 for 3 cycles during a hazard -> slots, selects and stall_cnt unchanged.
REQ-038 rst asserted asynchronously mid-stall -> stall, selects, stall_cnt =0 before next clk edge; stall_cnt preloaded near all-ones -> saturates at 16'hFFFF.
